// File: rtl/fp_div_requester_pkg.sv
// Shared types and constants for the FP divide requester.
package fp_div_requester_pkg;

    localparam int unsigned WordWidth  = 32;
    localparam int unsigned DivLatency = 7;

    typedef enum logic [1:0] {
        StFlush,
        StIdle,
        StIssue,
        StWait
    } state_e;

endpackage

// File: rtl/fp_pair_fifo.sv
// Synchronous FIFO holding (dividend, divisor) pairs awaiting issue.
module fp_pair_fifo
    import fp_div_requester_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 2 * WordWidth
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fp_div_requester.sv
// Buffers operand pairs, drives the start/done FP divider handshake and
// returns quotients in order, with a watchdog against a hung divider.
module fp_div_requester
    import fp_div_requester_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned FLUSH_CYCLES   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WordWidth-1:0] in_dataa,
    input  logic [WordWidth-1:0] in_datab,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WordWidth-1:0] out_result,
    output logic                 div_clk_en,
    output logic [WordWidth-1:0] div_dataa,
    output logic [WordWidth-1:0] div_datab,
    input  logic [WordWidth-1:0] div_result,
    input  logic                 div_done,
    output logic                 timeout_err
);

    // A watchdog shorter than the divider latency would abort every operation.
    localparam int unsigned TimeoutLim =
        (TIMEOUT_CYCLES > DivLatency) ? TIMEOUT_CYCLES : DivLatency + 1;
    localparam int unsigned CntMax = (TimeoutLim > FLUSH_CYCLES) ? TimeoutLim : FLUSH_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TimeoutLim);
    localparam logic [CntW-1:0] FlushLast  = CntW'(FLUSH_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [WordWidth-1:0]   dataa_q, dataa_d, datab_q, datab_d;
    logic [WordWidth-1:0]   result_q, result_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [2*WordWidth-1:0] fifo_rdata;

    assign in_ready    = (state_q != StFlush) && !fifo_full;
    assign fifo_push   = in_valid && in_ready;
    assign div_clk_en  = (state_q == StIssue);
    assign div_dataa   = dataa_q;
    assign div_datab   = datab_q;
    assign out_valid   = valid_q;
    assign out_result  = result_q;
    assign timeout_err = err_q;

    fp_pair_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * WordWidth)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .wdata ({in_dataa, in_datab}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dataa_d  = dataa_q;
        datab_d  = datab_q;
        result_d = result_q;
        valid_d  = valid_q;
        err_d    = err_q;
        fifo_pop = 1'b0;
        if (out_ready) valid_d = 1'b0;

        unique case (state_q)
            StFlush: begin
                if (cnt_q == FlushLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StIdle: begin
                cnt_d = '0;
                if (!fifo_empty && (!valid_q || out_ready)) begin
                    fifo_pop = 1'b1;
                    dataa_d  = fifo_rdata[2*WordWidth-1:WordWidth];
                    datab_d  = fifo_rdata[WordWidth-1:0];
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // A done coincident with expiry still counts as success.
                if (div_done) begin
                    valid_d  = 1'b1;
                    result_d = div_result;
                    state_d  = StIdle;
                end else if (cnt_q == TimeoutVal) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StFlush;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StFlush;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StFlush;
            cnt_q    <= '0;
            dataa_q  <= '0;
            datab_q  <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dataa_q  <= dataa_d;
            datab_q  <= datab_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_fp_div_requester.sv
// Directed bench for fp_div_requester with a behavioural fixed-latency divider.
module tb_fp_div_requester;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_dataa, in_datab;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        div_clk_en;
    logic [31:0] div_dataa, div_datab;
    logic [31:0] div_result;
    logic        div_done;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int lat = 7;
    int div_cnt = 0;

    always #5 clock = ~clock;

    fp_div_requester #(
        .FIFO_DEPTH     (2),
        .TIMEOUT_CYCLES (16),
        .FLUSH_CYCLES   (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dataa    (in_dataa),
        .in_datab    (in_datab),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .div_clk_en  (div_clk_en),
        .div_dataa   (div_dataa),
        .div_datab   (div_datab),
        .div_result  (div_result),
        .div_done    (div_done),
        .timeout_err (timeout_err)
    );

    // Hand-computed IEEE-754 quotients for the operand pairs used here.
    function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] key;
        key = {a, b};
        case (key)
            64'h40C00000_40000000: return 32'h40400000; // 6/2
            64'h3F800000_40800000: return 32'h3E800000; // 1/4
            64'h41000000_40000000: return 32'h40800000; // 8/2
            64'h3F800000_40000000: return 32'h3F000000; // 1/2
            64'h41200000_40800000: return 32'h40200000; // 10/4
            default:               return 32'hFFFFFFFF;
        endcase
    endfunction

    // Divider has no reset and reads the operand ports only when done.
    always @(posedge clock) begin
        if (div_clk_en) div_cnt <= lat;
        else if (div_cnt > 0) div_cnt <= div_cnt - 1;
    end
    assign div_done   = (div_cnt == 1);
    assign div_result = div_done ? quot(div_dataa, div_datab) : 32'h0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_dataa = a;
        in_datab = b;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_wait: in_ready=%b want 1 within 50 cycles", in_ready);
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_dataa = '0; in_datab = '0; out_ready = 1'b1;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL rst_out_result: got %h want 0", out_result); end
        checks++; if (div_clk_en !== 1'b0) begin errors++; $display("FAIL rst_div_clk_en: got %b want 0", div_clk_en); end
        checks++; if (div_dataa !== 32'h0 || div_datab !== 32'h0) begin errors++; $display("FAIL rst_div_data: got %h/%h want 0/0", div_dataa, div_datab); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (in_ready !== 1'b0 || div_clk_en !== 1'b0) begin
                errors++;
                $display("FAIL flush_cycle_%0d: in_ready=%b div_clk_en=%b want 0/0", i, in_ready, div_clk_en);
            end
            tick();
        end
        checks++;
        if (in_ready !== 1'b1 || div_clk_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_exit: in_ready=%b div_clk_en=%b want 1/0", in_ready, div_clk_en);
        end
    endtask

    task automatic test_single();
        int nstb = 0, first_stb = -1, first_val = -1;
        logic [31:0] got = '0;
        push_pair(32'h40C00000, 32'h40000000);
        for (int k = 1; k <= 14; k++) begin
            if (div_clk_en) begin nstb++; if (first_stb < 0) first_stb = k; end
            if (out_valid && first_val < 0) begin first_val = k; got = out_result; end
            tick();
        end
        checks++; if (nstb != 1) begin errors++; $display("FAIL single_strobe_count: got %0d want 1", nstb); end
        checks++; if (first_stb != 2) begin errors++; $display("FAIL single_strobe_cycle: got %0d want 2", first_stb); end
        checks++; if (first_val != 10) begin errors++; $display("FAIL single_latency: got %0d want 10", first_val); end
        checks++; if (got !== 32'h40400000) begin errors++; $display("FAIL single_result: got %h want 40400000", got); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_out_clear: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] pairs [3] = '{64'h41000000_40000000, 64'h3F800000_40800000,
                                   64'h41200000_40800000};
        logic [31:0] expq [3] = '{32'h40800000, 32'h3E800000, 32'h40200000};
        logic [31:0] res [3];
        int stb [3];
        int idx = 0, nres = 0, nstb = 0, first_res = -1;
        logic acc;
        in_valid = 1'b1;
        {in_dataa, in_datab} = pairs[0];
        for (int k = 0; k < 40; k++) begin
            if (div_clk_en) begin if (nstb < 3) stb[nstb] = k; nstb++; end
            if (out_valid) begin
                if (nres < 3) res[nres] = out_result;
                if (first_res < 0) first_res = k;
                nres++;
            end
            if (k == 3) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: in_ready=%b want 0", in_ready); end
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 3) {in_dataa, in_datab} = pairs[idx];
                else in_valid = 1'b0;
            end
        end
        checks++; if (idx != 3) begin errors++; $display("FAIL b2b_accepted: got %0d want 3", idx); end
        checks++; if (nstb != 3) begin errors++; $display("FAIL b2b_strobes: got %0d want 3", nstb); end
        checks++; if (stb[0] != 2) begin errors++; $display("FAIL b2b_first_strobe: got %0d want 2", stb[0]); end
        checks++; if (stb[1] - stb[0] != 9 || stb[2] - stb[1] != 9) begin
            errors++; $display("FAIL b2b_spacing: got %0d,%0d want 9,9", stb[1] - stb[0], stb[2] - stb[1]); end
        checks++; if (nres != 3) begin errors++; $display("FAIL b2b_result_count: got %0d want 3", nres); end
        checks++; if (first_res != 10) begin errors++; $display("FAIL b2b_first_result: got %0d want 10", first_res); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (res[i] !== expq[i]) begin errors++; $display("FAIL b2b_result_%0d: got %h want %h", i, res[i], expq[i]); end
        end
    endtask

    task automatic test_backpressure();
        int nstb = 0, n = 0;
        logic seen = 1'b0;
        logic [31:0] res [2];
        out_ready = 1'b0;
        push_pair(32'h40C00000, 32'h40000000);
        push_pair(32'h3F800000, 32'h40000000);
        for (int k = 0; k < 30; k++) begin
            if (div_clk_en) nstb++;
            if (seen) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== 32'h40400000) begin
                    errors++;
                    $display("FAIL bp_hold_%0d: valid=%b result=%h want 1/40400000", k, out_valid, out_result);
                end
            end else if (out_valid) begin
                seen = 1'b1;
                checks++;
                if (out_result !== 32'h40400000) begin errors++; $display("FAIL bp_first: got %h want 40400000", out_result); end
            end
            tick();
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL bp_no_result: got %b want 1", seen); end
        checks++; if (nstb != 1) begin errors++; $display("FAIL bp_stalled_issue: strobes %0d want 1", nstb); end
        out_ready = 1'b1;
        nstb = 0;
        for (int k = 0; k < 15; k++) begin
            if (div_clk_en) nstb++;
            if (out_valid) begin if (n < 2) res[n] = out_result; n++; end
            tick();
        end
        checks++; if (n != 2) begin errors++; $display("FAIL bp_transfers: got %0d want 2", n); end
        checks++; if (nstb != 1) begin errors++; $display("FAIL bp_resume_strobe: got %0d want 1", nstb); end
        checks++; if (res[0] !== 32'h40400000 || res[1] !== 32'h3F000000) begin
            errors++; $display("FAIL bp_order: got %h,%h want 40400000,3F000000", res[0], res[1]); end
    endtask

    task automatic test_timeout();
        int nstb = 0, nval = 0, s = -1;
        lat = 20;
        push_pair(32'h40C00000, 32'h40000000);
        for (int k = 0; k < 40; k++) begin
            if (div_clk_en) begin nstb++; if (s < 0) s = k; end
            if (out_valid) nval++;
            if (s >= 0 && k - s == 16) begin
                checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", timeout_err); end
            end
            if (s >= 0 && k - s == 18) begin
                checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_set: got %b want 1", timeout_err); end
            end
            if (s >= 0 && k - s == 20) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL to_flush: in_ready=%b want 0", in_ready); end
            end
            if (s >= 0 && k - s == 30) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL to_recover: in_ready=%b want 1", in_ready); end
            end
            tick();
        end
        lat = 7;
        checks++; if (nstb != 1) begin errors++; $display("FAIL to_strobes: got %0d want 1", nstb); end
        checks++; if (nval != 0) begin errors++; $display("FAIL to_spurious_out: got %0d want 0", nval); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
    endtask

    task automatic test_reset_mid();
        int nstb = 0, nval = 0, first_val = -1;
        logic [31:0] got = '0;
        push_pair(32'h3F800000, 32'h40800000);
        push_pair(32'h41000000, 32'h40000000);
        checks++; if (div_clk_en !== 1'b1) begin errors++; $display("FAIL rm_strobe: got %b want 1", div_clk_en); end
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || div_clk_en !== 1'b0) begin
            errors++; $display("FAIL rm_ctrl: in_ready=%b out_valid=%b div_clk_en=%b want 0/0/0", in_ready, out_valid, div_clk_en); end
        checks++; if (out_result !== 32'h0 || div_dataa !== 32'h0 || div_datab !== 32'h0) begin
            errors++; $display("FAIL rm_data: %h %h %h want 0 0 0", out_result, div_dataa, div_datab); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rm_err_clear: got %b want 0", timeout_err); end
        for (int k = 0; k < 16; k++) begin
            if (div_clk_en) nstb++;
            if (out_valid) nval++;
            tick();
        end
        checks++; if (nstb != 0 || nval != 0) begin
            errors++; $display("FAIL rm_dropped: strobes=%0d outputs=%0d want 0/0", nstb, nval); end
        nstb = 0;
        push_pair(32'h41200000, 32'h40800000);
        for (int k = 1; k <= 14; k++) begin
            if (div_clk_en) nstb++;
            if (out_valid && first_val < 0) begin first_val = k; got = out_result; end
            tick();
        end
        checks++; if (nstb != 1) begin errors++; $display("FAIL rm_next_strobes: got %0d want 1", nstb); end
        checks++; if (first_val != 10) begin errors++; $display("FAIL rm_next_latency: got %0d want 10", first_val); end
        checks++; if (got !== 32'h40200000) begin errors++; $display("FAIL rm_next_result: got %h want 40200000", got); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
